seq_ctrl: RTL and testbench

Single-issue instruction controller that sequences the `seq_alu` datapath. It accepts one instruction at a time over a valid/ready port and reads operands from a small internal register file. It drives the ALU with registered operands, waits for the ALU result (zero-cycle or pipelined), and writes the result back. `send` instructions skip the ALU and emit a register value on a back-pressured output port. It sits between the instruction source and `seq_alu`.

---
 rtl/seq_ctrl_if.sv | 53 +++++
 rtl/seq_ctrl.sv | 122 ++++++++++++
 tb/tb_seq_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_if.sv
// Instruction, ALU and send ports of seq_ctrl grouped into one bundle.
// Handshakes: a transfer happens on any clock edge where valid and ready are
// both high. A valid source holds its payload stable until that edge, and
// ready may depend on state but never on the same cycle's valid.
// The ALU result port has no ready: i_alu_valid marks a one-cycle result.
interface seq_ctrl_if #(
  parameter int alu_width    = 16,
  parameter int seq_op_width = 2,
  parameter int seq_im_width = 8,
  parameter int num_regs     = 4
);
  localparam int reg_aw = $clog2(num_regs);

  logic                    i_inst_valid;
  logic                    o_inst_ready;
  logic [seq_op_width-1:0] i_inst_op;
  logic [reg_aw-1:0]       i_inst_rd;
  logic [reg_aw-1:0]       i_inst_ra;
  logic [reg_aw-1:0]       i_inst_rb;
  logic [seq_im_width-1:0] i_inst_imm;

  logic [alu_width-1:0]    o_alu_data_a;
  logic [alu_width-1:0]    o_alu_data_b;
  logic [seq_op_width-1:0] o_alu_op;
  logic [seq_im_width-1:0] o_alu_const;
  logic                    o_alu_valid;
  logic [alu_width-1:0]    i_alu_data;
  logic                    i_alu_valid;

  logic [alu_width-1:0]    o_send_data;
  logic                    o_send_valid;
  logic                    i_send_ready;

  // Controller side.
  modport master (
    input  i_inst_valid, i_inst_op, i_inst_rd, i_inst_ra, i_inst_rb, i_inst_imm,
    output o_inst_ready,
    output o_alu_data_a, o_alu_data_b, o_alu_op, o_alu_const, o_alu_valid,
    input  i_alu_data, i_alu_valid,
    output o_send_data, o_send_valid,
    input  i_send_ready
  );

  // Environment side: instruction source, ALU and send sink.
  modport slave (
    output i_inst_valid, i_inst_op, i_inst_rd, i_inst_ra, i_inst_rb, i_inst_imm,
    input  o_inst_ready,
    input  o_alu_data_a, o_alu_data_b, o_alu_op, o_alu_const, o_alu_valid,
    output i_alu_data, i_alu_valid,
    input  o_send_data, o_send_valid,
    output i_send_ready
  );
endinterface

// File: rtl/seq_ctrl.sv
// Single-issue controller for seq_alu: latches one instruction with its
// register operands, issues it to the ALU, waits (bounded) for the result and
// writes it back, or emits a register value on the send port.
module seq_ctrl #(
  parameter int alu_width    = 16,
  parameter int seq_op_width = 2,
  parameter int seq_im_width = 8,
  parameter int num_regs     = 4,
  parameter int timeout      = 16,
  parameter logic [seq_op_width-1:0] op_push = 0,
  parameter logic [seq_op_width-1:0] op_add  = 1,
  parameter logic [seq_op_width-1:0] op_send = 3
) (
  input  logic       clk,
  input  logic       rst,
  seq_ctrl_if.master bus,
  output logic       o_busy,
  output logic       o_err,
  output logic [1:0] o_dbg_state
);
  localparam int reg_aw = $clog2(num_regs);
  localparam int cnt_w  = $clog2(timeout + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [cnt_w-1:0]        cnt;
  logic [seq_op_width-1:0] lat_op;
  logic [reg_aw-1:0]       lat_rd;
  logic [seq_im_width-1:0] lat_imm;
  logic [alu_width-1:0]    lat_a;
  logic [alu_width-1:0]    lat_b;
  logic [alu_width-1:0]    regs [num_regs];
  logic                    err;

  logic accept;
  logic alu_done;
  logic wait_expire;

  // add decodes like any other ALU op here; only push and send are special.
  logic unused_params;
  assign unused_params = ^op_add;

  assign accept      = (state == S_IDLE) && bus.i_inst_valid;
  assign alu_done    = ((state == S_ISSUE) || (state == S_WAIT)) && bus.i_alu_valid;
  assign wait_expire = (state == S_WAIT) && !bus.i_alu_valid && (cnt == cnt_last);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; the ALU result beats the timeout in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = (bus.i_inst_op == op_send) ? S_SEND : S_ISSUE;
      S_ISSUE: state_n = bus.i_alu_valid ? S_IDLE : S_WAIT;
      S_WAIT:  if (bus.i_alu_valid || wait_expire) state_n = S_IDLE;
      S_SEND:  if (bus.i_send_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Instruction/operand latch on accept; push takes operand A from rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_op  <= '0;
      lat_rd  <= '0;
      lat_imm <= '0;
      lat_a   <= '0;
      lat_b   <= '0;
    end else if (accept) begin
      lat_op  <= bus.i_inst_op;
      lat_rd  <= bus.i_inst_rd;
      lat_imm <= bus.i_inst_imm;
      lat_a   <= (bus.i_inst_op == op_push) ? regs[bus.i_inst_rd] : regs[bus.i_inst_ra];
      lat_b   <= regs[bus.i_inst_rb];
    end
  end

  // WAIT cycle counter, cleared whenever the controller is outside WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (state == S_WAIT) cnt <= cnt + cnt_w'(1);
    else                     cnt <= '0;
  end

  // Register file: written only by ALU write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < num_regs; i++) regs[i] <= '0;
    end else if (alu_done) begin
      regs[lat_rd] <= bus.i_alu_data;
    end
  end

  // Sticky timeout flag; cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             err <= 1'b0;
    else if (wait_expire) err <= 1'b1;
  end

  assign bus.o_inst_ready = (state == S_IDLE);
  assign bus.o_alu_valid  = (state == S_ISSUE);
  assign bus.o_alu_data_a = lat_a;
  assign bus.o_alu_data_b = lat_b;
  assign bus.o_alu_op     = lat_op;
  assign bus.o_alu_const  = lat_imm;
  assign bus.o_send_valid = (state == S_SEND);
  assign bus.o_send_data  = lat_a;
  assign o_busy           = (state != S_IDLE);
  assign o_err            = err;
  assign o_dbg_state      = state;
endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a switchable ALU stub (combinational,
// 3-cycle pipelined, silent, or bench-driven) and a send-port scoreboard.
module tb_seq_ctrl;
  localparam int aw = 16;
  localparam int ow = 2;
  localparam int iw = 8;
  localparam int nr = 4;
  localparam int to = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       o_busy;
  logic       o_err;
  logic [1:0] dbg_state;

  seq_ctrl_if #(.alu_width(aw), .seq_op_width(ow), .seq_im_width(iw), .num_regs(nr)) bus ();

  seq_ctrl #(.alu_width(aw), .seq_op_width(ow), .seq_im_width(iw), .num_regs(nr),
             .timeout(to)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [aw-1:0] exp_q[$];
  int alu_mode = 0;
  int pipe_cnt = 0;
  logic late_valid = 1'b0;
  logic [aw-1:0] late_data = '0;
  int alu_pulses = 0;
  int send_beats = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ALU stub.
  always_comb begin
    bus.i_alu_valid = 1'b0;
    bus.i_alu_data  = '0;
    case (alu_mode)
      0: begin
        bus.i_alu_valid = bus.o_alu_valid;
        case (bus.o_alu_op)
          2'd0:    bus.i_alu_data = {bus.o_alu_data_a[7:0], bus.o_alu_const};
          2'd1:    bus.i_alu_data = bus.o_alu_data_a + bus.o_alu_data_b;
          default: bus.i_alu_data = bus.o_alu_data_a;
        endcase
      end
      1: begin
        bus.i_alu_valid = (pipe_cnt == 1);
        bus.i_alu_data  = 16'hBEEF;
      end
      3: begin
        bus.i_alu_valid = late_valid;
        bus.i_alu_data  = late_data;
      end
      default: ;
    endcase
  end

  // Pipelined stub: result three cycles after the issue cycle.
  always @(posedge clk) begin
    if (alu_mode == 1 && bus.o_alu_valid) pipe_cnt <= 3;
    else if (pipe_cnt != 0)               pipe_cnt <= pipe_cnt - 1;
  end

  // Monitor: count issue pulses, score send handshakes against exp_q.
  always @(negedge clk) begin
    if (bus.o_alu_valid) alu_pulses++;
    if (bus.o_send_valid && bus.i_send_ready) begin
      send_beats++;
      check("send_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("send_data", bus.o_send_data, exp_q.pop_front());
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [7:0] imm);
    int n = 0;
    while (!bus.o_inst_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.o_inst_ready) check("inst_ready_wait", {31'd0, bus.o_inst_ready}, 32'd1);
    bus.i_inst_op    = op;
    bus.i_inst_rd    = rd;
    bus.i_inst_ra    = ra;
    bus.i_inst_rb    = rb;
    bus.i_inst_imm   = imm;
    bus.i_inst_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_inst_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (o_busy && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                        input int exp_cycles);
    int p0;
    int c;
    p0 = alu_pulses;
    issue(op, rd, ra, rb, imm);
    wait_idle(c);
    check({tag, "_cycles"}, c, exp_cycles);
    check({tag, "_pulses"}, alu_pulses - p0, 1);
  endtask

  task automatic do_send(input string tag, input logic [1:0] ra, input logic [aw-1:0] exp,
                         input int hold);
    int b0;
    int c;
    exp_q.push_back(exp);
    bus.i_send_ready = (hold == 0);
    b0 = send_beats;
    issue(2'd3, 2'd0, ra, 2'd0, 8'd0);
    check({tag, "_valid"}, {31'd0, bus.o_send_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, {31'd0, bus.o_send_valid}, 32'd1);
      check({tag, "_hold_data"}, bus.o_send_data, exp);
      check({tag, "_hold_ready"}, {31'd0, bus.o_inst_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.i_send_ready = 1'b1;
    wait_idle(c);
    check({tag, "_cycles"}, c, 1);
    check({tag, "_beats"}, send_beats - b0, 1);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    bus.i_inst_valid = 1'b0;
    bus.i_inst_op    = '0;
    bus.i_inst_rd    = '0;
    bus.i_inst_ra    = '0;
    bus.i_inst_rb    = '0;
    bus.i_inst_imm   = '0;
    bus.i_send_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_alu_valid", {31'd0, bus.o_alu_valid}, 32'd0);
    check("rst_alu_a", bus.o_alu_data_a, 32'd0);
    check("rst_send_valid", {31'd0, bus.o_send_valid}, 32'd0);
    check("rst_send_data", bus.o_send_data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_inst_ready", {31'd0, bus.o_inst_ready}, 32'd1);
    check("rst_state", dbg_state, 32'd0);

    // Pushes and add with the combinational ALU.
    run_op("push1", 2'd0, 2'd0, 2'd0, 2'd0, 8'h12, 1);
    do_send("rd0a", 2'd0, 16'h0012, 0);
    run_op("push2", 2'd0, 2'd0, 2'd0, 2'd0, 8'h34, 1);
    do_send("rd0b", 2'd0, 16'h1234, 0);
    run_op("add", 2'd1, 2'd1, 2'd0, 2'd0, 8'h00, 1);
    do_send("rd1", 2'd1, 16'h2468, 0);
    check("add_err", {31'd0, o_err}, 32'd0);

    // Send backpressure for five cycles.
    do_send("bp", 2'd1, 16'h2468, 5);

    // Pipelined ALU: ISSUE plus three WAIT cycles.
    alu_mode = 1;
    run_op("pipe", 2'd1, 2'd2, 2'd0, 2'd1, 8'h00, 4);
    alu_mode = 0;
    do_send("rd2", 2'd2, 16'hBEEF, 0);

    // Timeout: ISSUE plus eight WAIT cycles, no write-back.
    alu_mode = 2;
    check("tmo_err_before", {31'd0, o_err}, 32'd0);
    run_op("tmo", 2'd1, 2'd2, 2'd0, 2'd1, 8'h00, 9);
    check("tmo_err", {31'd0, o_err}, 32'd1);
    alu_mode = 0;
    do_send("rd2_kept", 2'd2, 16'hBEEF, 0);
    run_op("push3", 2'd0, 2'd3, 2'd0, 2'd0, 8'h56, 1);
    do_send("rd3", 2'd3, 16'h0056, 0);
    check("err_sticky", {31'd0, o_err}, 32'd1);

    // Reset during WAIT, then a late ALU result.
    alu_mode = 3;
    issue(2'd1, 2'd1, 2'd0, 2'd1, 8'h00);
    @(posedge clk); #1;
    check("mid_state_wait", dbg_state, 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_busy", {31'd0, o_busy}, 32'd0);
    check("mid_err", {31'd0, o_err}, 32'd0);
    check("mid_alu_valid", {31'd0, bus.o_alu_valid}, 32'd0);
    check("mid_send_valid", {31'd0, bus.o_send_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    late_data  = 16'hDEAD;
    late_valid = 1'b1;
    @(posedge clk); #1;
    late_valid = 1'b0;
    check("late_busy", {31'd0, o_busy}, 32'd0);
    alu_mode = 0;
    for (int r = 0; r < nr; r++) begin
      do_send($sformatf("post_rst_r%0d", r), 2'(r), 16'h0000, 0);
    end

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
